// File: rtl/router_reg.sv
// Router register block: header capture, byte steering to the destination FIFO, parity and error tracking.
// Optional payload length check is compiled in when ROUTER_REG_LEN_CHECK_EN is defined.
module router_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic       fifo_full,
  input  logic       rst_int_reg,
  input  logic       detect_add,
  input  logic       ld_state,
  input  logic       laf_state,
  input  logic       full_state,
  input  logic       lfd_state,
  output logic       parity_done,
  output logic       low_pkt_valid,
  output logic       err,
  output logic [7:0] dout
);

  logic [7:0] header_reg;
  logic [7:0] hold_reg;
  logic [7:0] int_parity_reg;
  logic [7:0] pkt_parity_reg;
  logic       parity_done_d_reg;

  logic hdr_bad;
  logic pkt_clr;
  logic hdr_load;
  logic xor_en;
  logic pd_set;
  logic len_bad;
  logic mismatch;

  // A header addressed to port 3 is not ours to act on, so it must not disturb any state.
  assign hdr_bad  = detect_add & pkt_valid & (data_in[1:0] == 2'b11);
  assign pkt_clr  = detect_add & ~hdr_bad;
  assign hdr_load = pkt_clr & pkt_valid;
  assign xor_en   = ld_state & pkt_valid & ~full_state;
  assign pd_set   = (ld_state & ~fifo_full & ~pkt_valid) |
                    (laf_state & low_pkt_valid & ~parity_done);

`ifdef ROUTER_REG_LEN_CHECK_EN
  logic [5:0] len_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      len_cnt_reg <= 6'd0;
    else if (pkt_clr)
      len_cnt_reg <= 6'd0;
    else if (xor_en)
      len_cnt_reg <= len_cnt_reg + 6'd1;
  end

  assign len_bad = (len_cnt_reg != header_reg[7:2]);
`else
  assign len_bad = 1'b0;
`endif

  assign mismatch = (int_parity_reg != pkt_parity_reg) | len_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      header_reg <= 8'h00;
      hold_reg   <= 8'h00;
      dout       <= 8'h00;
    end else begin
      if (hdr_load)
        header_reg <= data_in;
      // The byte offered while the FIFO is full is parked and replayed in LOAD_AFTER_FULL.
      if (ld_state && fifo_full)
        hold_reg <= data_in;
      if (lfd_state)
        dout <= header_reg;
      else if (ld_state && !fifo_full)
        dout <= data_in;
      else if (laf_state)
        dout <= hold_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_parity_reg    <= 8'h00;
      pkt_parity_reg    <= 8'h00;
      parity_done       <= 1'b0;
      parity_done_d_reg <= 1'b0;
      err               <= 1'b0;
    end else begin
      parity_done_d_reg <= parity_done;
      if (pkt_clr) begin
        int_parity_reg <= 8'h00;
        pkt_parity_reg <= 8'h00;
        parity_done    <= 1'b0;
        err            <= 1'b0;
      end else begin
        if (lfd_state)
          int_parity_reg <= int_parity_reg ^ header_reg;
        else if (xor_en)
          int_parity_reg <= int_parity_reg ^ data_in;
        if (pd_set) begin
          parity_done    <= 1'b1;
          pkt_parity_reg <= data_in;
        end
        // Evaluate exactly once, the cycle after parity_done rises.
        if (parity_done && !parity_done_d_reg && mismatch)
          err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      low_pkt_valid <= 1'b0;
    else if (rst_int_reg)
      low_pkt_valid <= 1'b0;
    else if (ld_state && !pkt_valid)
      low_pkt_valid <= 1'b1;
  end

endmodule

// File: tb/tb_router_reg.sv
// Directed self-checking bench for router_reg; one task per scenario.
module tb_router_reg;

  localparam logic [4:0] S_IDLE = 5'b00000;
  localparam logic [4:0] S_DET  = 5'b00001;
  localparam logic [4:0] S_LD   = 5'b00010;
  localparam logic [4:0] S_LAF  = 5'b00100;
  localparam logic [4:0] S_FULL = 5'b01000;
  localparam logic [4:0] S_LFD  = 5'b10000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       fifo_full = 1'b0;
  logic       rst_int_reg = 1'b0;
  logic       detect_add = 1'b0;
  logic       ld_state = 1'b0;
  logic       laf_state = 1'b0;
  logic       full_state = 1'b0;
  logic       lfd_state = 1'b0;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       err;
  logic [7:0] dout;

  int total = 0;
  int bad = 0;
  logic exp_len_err;

  router_reg dut (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .rst_int_reg(rst_int_reg), .detect_add(detect_add),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .lfd_state(lfd_state), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .err(err), .dout(dout)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, then sample point is 1ns after the rising edge.
  task automatic cyc(input logic [4:0] st, input logic pv, input logic [7:0] d,
                     input logic ff, input logic ri);
    detect_add  = st[0];
    ld_state    = st[1];
    laf_state   = st[2];
    full_state  = st[3];
    lfd_state   = st[4];
    pkt_valid   = pv;
    data_in     = d;
    fifo_full   = ff;
    rst_int_reg = ri;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cyc(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b0);
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
    total++; if (parity_done !== 1'b0) begin bad++; $display("FAIL reset_pd got=%b exp=0", parity_done); end
    total++; if (low_pkt_valid !== 1'b0) begin bad++; $display("FAIL reset_lpv got=%b exp=0", low_pkt_valid); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    reset = 1'b0;
    cyc(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b0);
    $display("test_reset: done");
  endtask

  task automatic test_good_packet;
    cyc(S_DET, 1'b1, 8'h0D, 1'b0, 1'b0);
    cyc(S_LFD, 1'b1, 8'h11, 1'b0, 1'b0);
    total++; if (dout !== 8'h0D) begin bad++; $display("FAIL good_hdr got=%h exp=0d", dout); end
    cyc(S_LD, 1'b1, 8'h11, 1'b0, 1'b0);
    total++; if (dout !== 8'h11) begin bad++; $display("FAIL good_b1 got=%h exp=11", dout); end
    cyc(S_LD, 1'b1, 8'h22, 1'b0, 1'b0);
    total++; if (dout !== 8'h22) begin bad++; $display("FAIL good_b2 got=%h exp=22", dout); end
    cyc(S_LD, 1'b1, 8'h33, 1'b0, 1'b0);
    total++; if (dout !== 8'h33) begin bad++; $display("FAIL good_b3 got=%h exp=33", dout); end
    total++; if (parity_done !== 1'b0) begin bad++; $display("FAIL good_pd_early got=%b exp=0", parity_done); end
    cyc(S_LD, 1'b0, 8'h0D, 1'b0, 1'b0);
    total++; if (parity_done !== 1'b1) begin bad++; $display("FAIL good_pd got=%b exp=1", parity_done); end
    total++; if (low_pkt_valid !== 1'b1) begin bad++; $display("FAIL good_lpv got=%b exp=1", low_pkt_valid); end
    total++; if (dout !== 8'h0D) begin bad++; $display("FAIL good_par_out got=%h exp=0d", dout); end
    cyc(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b1);
    total++; if (low_pkt_valid !== 1'b0) begin bad++; $display("FAIL good_lpv_clr got=%b exp=0", low_pkt_valid); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL good_err got=%b exp=0", err); end
    $display("test_good_packet: done");
  endtask

  task automatic test_bad_parity;
    cyc(S_DET, 1'b1, 8'h0D, 1'b0, 1'b0);
    cyc(S_LFD, 1'b1, 8'h11, 1'b0, 1'b0);
    cyc(S_LD, 1'b1, 8'h11, 1'b0, 1'b0);
    cyc(S_LD, 1'b1, 8'h22, 1'b0, 1'b0);
    cyc(S_LD, 1'b1, 8'h33, 1'b0, 1'b0);
    cyc(S_LD, 1'b0, 8'h0C, 1'b0, 1'b0);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL bad_err_early got=%b exp=0", err); end
    cyc(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b1);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL bad_err got=%b exp=1", err); end
    cyc(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL bad_err_hold got=%b exp=1", err); end
    // Port-3 header is ignored: err, parity_done and header register survive.
    cyc(S_DET, 1'b1, 8'h0F, 1'b0, 1'b0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL addr3_err got=%b exp=1", err); end
    total++; if (parity_done !== 1'b1) begin bad++; $display("FAIL addr3_pd got=%b exp=1", parity_done); end
    cyc(S_LFD, 1'b1, 8'h00, 1'b0, 1'b0);
    total++; if (dout !== 8'h0D) begin bad++; $display("FAIL addr3_hdr got=%h exp=0d", dout); end
    cyc(S_DET, 1'b1, 8'h0D, 1'b0, 1'b0);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL bad_err_clr got=%b exp=0", err); end
    total++; if (parity_done !== 1'b0) begin bad++; $display("FAIL bad_pd_clr got=%b exp=0", parity_done); end
    $display("test_bad_parity: done");
  endtask

  task automatic test_fifo_full;
    cyc(S_DET, 1'b1, 8'h0D, 1'b0, 1'b0);
    cyc(S_LFD, 1'b1, 8'h11, 1'b0, 1'b0);
    cyc(S_LD, 1'b1, 8'h11, 1'b0, 1'b0);
    cyc(S_LD, 1'b1, 8'h22, 1'b1, 1'b0);
    total++; if (dout !== 8'h11) begin bad++; $display("FAIL full_hold_dout got=%h exp=11", dout); end
    cyc(S_FULL, 1'b1, 8'h22, 1'b1, 1'b0);
    total++; if (dout !== 8'h11) begin bad++; $display("FAIL full_state_dout got=%h exp=11", dout); end
    cyc(S_LAF, 1'b1, 8'h22, 1'b0, 1'b0);
    total++; if (dout !== 8'h22) begin bad++; $display("FAIL full_laf_dout got=%h exp=22", dout); end
    total++; if (parity_done !== 1'b0) begin bad++; $display("FAIL full_laf_pd got=%b exp=0", parity_done); end
    cyc(S_LD, 1'b1, 8'h33, 1'b0, 1'b0);
    total++; if (dout !== 8'h33) begin bad++; $display("FAIL full_b3 got=%h exp=33", dout); end
    cyc(S_LD, 1'b0, 8'h0D, 1'b0, 1'b0);
    total++; if (parity_done !== 1'b1) begin bad++; $display("FAIL full_pd got=%b exp=1", parity_done); end
    cyc(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b1);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL full_err got=%b exp=0", err); end
    $display("test_fifo_full: done");
  endtask

  task automatic test_low_pkt_full;
    cyc(S_DET, 1'b1, 8'h0D, 1'b0, 1'b0);
    cyc(S_LFD, 1'b1, 8'h11, 1'b0, 1'b0);
    cyc(S_LD, 1'b1, 8'h11, 1'b0, 1'b0);
    cyc(S_LD, 1'b1, 8'h22, 1'b0, 1'b0);
    cyc(S_LD, 1'b1, 8'h33, 1'b0, 1'b0);
    cyc(S_LD, 1'b0, 8'h0D, 1'b1, 1'b0);
    total++; if (low_pkt_valid !== 1'b1) begin bad++; $display("FAIL lpf_lpv got=%b exp=1", low_pkt_valid); end
    total++; if (parity_done !== 1'b0) begin bad++; $display("FAIL lpf_pd_ld got=%b exp=0", parity_done); end
    cyc(S_FULL, 1'b0, 8'h0D, 1'b1, 1'b0);
    total++; if (parity_done !== 1'b0) begin bad++; $display("FAIL lpf_pd_full got=%b exp=0", parity_done); end
    cyc(S_LAF, 1'b0, 8'h0D, 1'b0, 1'b0);
    total++; if (parity_done !== 1'b1) begin bad++; $display("FAIL lpf_pd_laf got=%b exp=1", parity_done); end
    total++; if (dout !== 8'h0D) begin bad++; $display("FAIL lpf_dout got=%h exp=0d", dout); end
    cyc(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b1);
    total++; if (low_pkt_valid !== 1'b0) begin bad++; $display("FAIL lpf_lpv_clr got=%b exp=0", low_pkt_valid); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL lpf_err got=%b exp=0", err); end
    $display("test_low_pkt_full: done");
  endtask

  task automatic test_reset_mid;
    cyc(S_DET, 1'b1, 8'h0D, 1'b0, 1'b0);
    cyc(S_LFD, 1'b1, 8'h11, 1'b0, 1'b0);
    cyc(S_LD, 1'b1, 8'h11, 1'b0, 1'b0);
    ld_state = 1'b1; lfd_state = 1'b0; detect_add = 1'b0;
    pkt_valid = 1'b1; data_in = 8'h22;
    #2 reset = 1'b1;
    #1;
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL rmid_dout got=%h exp=00", dout); end
    total++; if ({parity_done, low_pkt_valid, err} !== 3'b000) begin
      bad++; $display("FAIL rmid_flags got=%b exp=000", {parity_done, low_pkt_valid, err});
    end
    cyc(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    cyc(S_DET, 1'b1, 8'h08, 1'b0, 1'b0);
    cyc(S_LFD, 1'b1, 8'hAA, 1'b0, 1'b0);
    total++; if (dout !== 8'h08) begin bad++; $display("FAIL rmid_hdr got=%h exp=08", dout); end
    cyc(S_LD, 1'b1, 8'hAA, 1'b0, 1'b0);
    cyc(S_LD, 1'b1, 8'h55, 1'b0, 1'b0);
    total++; if (dout !== 8'h55) begin bad++; $display("FAIL rmid_b2 got=%h exp=55", dout); end
    cyc(S_LD, 1'b0, 8'hF7, 1'b0, 1'b0);
    total++; if (parity_done !== 1'b1) begin bad++; $display("FAIL rmid_pd got=%b exp=1", parity_done); end
    cyc(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b1);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rmid_err got=%b exp=0", err); end
    $display("test_reset_mid: done");
  endtask

  task automatic test_detect_wins;
    cyc(S_DET | S_LD, 1'b0, 8'h5A, 1'b0, 1'b0);
    total++; if (parity_done !== 1'b0) begin bad++; $display("FAIL dw_pd got=%b exp=0", parity_done); end
    cyc(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b1);
    total++; if (parity_done !== 1'b0) begin bad++; $display("FAIL dw_pd_hold got=%b exp=0", parity_done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL dw_err got=%b exp=0", err); end
    $display("test_detect_wins: done");
  endtask

  task automatic test_len;
`ifdef ROUTER_REG_LEN_CHECK_EN
    exp_len_err = 1'b1;
`else
    exp_len_err = 1'b0;
`endif
    cyc(S_DET, 1'b1, 8'h11, 1'b0, 1'b0);
    cyc(S_LFD, 1'b1, 8'h01, 1'b0, 1'b0);
    cyc(S_LD, 1'b1, 8'h01, 1'b0, 1'b0);
    cyc(S_LD, 1'b1, 8'h02, 1'b0, 1'b0);
    cyc(S_LD, 1'b1, 8'h03, 1'b0, 1'b0);
    cyc(S_LD, 1'b0, 8'h11, 1'b0, 1'b0);
    total++; if (parity_done !== 1'b1) begin bad++; $display("FAIL len_pd got=%b exp=1", parity_done); end
    cyc(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b1);
    total++; if (err !== exp_len_err) begin bad++; $display("FAIL len_err got=%b exp=%b", err, exp_len_err); end
    $display("test_len: done");
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_parity();
    test_fifo_full();
    test_low_pkt_full();
    test_reset_mid();
    test_detect_wins();
    test_len();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
